// File: rtl/op_fetch_sequencer.sv
// op_fetch_sequencer
// Sequences one sweep of operand fetch, ALU execution and result write-back.
// Each sweep covers ROM addresses 0..LAST_ADDR, and each address takes three
// steps: FETCH, EXEC and WRITE.
//   FETCH : enable both operand ROMs, then register their words into alu_a/alu_b.
//   EXEC  : register the combinational ALU result and the address for the RAM write.
//   WRITE : hold we_RAM high until ram_ready accepts the write.
// After the last write, done pulses for one cycle and the block returns to IDLE.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start, op_sel     begin a sweep (sampled in IDLE only); ALU operation latched at start
//   en_ROM, addr_ROM  enable and address shared by both operand ROMs
//   op1_d, op2_d      operand ROM words
//   alu_a, alu_b      registered operands; alu_sel is the latched operation
//   alu_res           combinational ALU result
//   we_RAM, addr_RAM, din_RAM, ram_ready   result RAM write handshake
//   busy, done        status: busy outside IDLE; done pulses once per sweep
module op_fetch_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int LAST_ADDR = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  op_sel,
  output logic              en_ROM,
  output logic [ADDR_W-1:0] addr_ROM,
  input  logic [DATA_W-1:0] op1_d,
  input  logic [DATA_W-1:0] op2_d,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  output logic              we_RAM,
  output logic [ADDR_W-1:0] addr_RAM,
  output logic [DATA_W-1:0] din_RAM,
  input  logic              ram_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] count_r;

  // The counter drives the ROM address directly, so the address holds steady through EXEC and WRITE.
  assign addr_ROM = count_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode. The sweep ends at LAST before any increment, so the counter never wraps.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: state_s = EXEC;
      EXEC:  state_s = WRITE;
      WRITE: begin
        if (ram_ready) begin
          if (count_r == LAST) begin
            state_s = DONE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control outputs are registered from the next state, so they switch together with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_ROM <= 1'b0;
      we_RAM <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      en_ROM <= (state_s == FETCH);
      we_RAM <= (state_s == WRITE);
      busy   <= (state_s != IDLE);
      done   <= (state_s == DONE);
    end
  end

  // Datapath registers. Operands are captured only in FETCH, so undriven ROM outputs are never registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {ADDR_W{1'b0}};
      alu_a    <= {DATA_W{1'b0}};
      alu_b    <= {DATA_W{1'b0}};
      alu_sel  <= {SEL_W{1'b0}};
      addr_RAM <= {ADDR_W{1'b0}};
      din_RAM  <= {DATA_W{1'b0}};
    end else begin
      if (state_r == IDLE && start) begin
        alu_sel <= op_sel;
        count_r <= {ADDR_W{1'b0}};
      end else if (state_r == WRITE && ram_ready && count_r != LAST) begin
        count_r <= count_r + ADDR_W'(1);
      end
      if (state_r == FETCH) begin
        alu_a <= op1_d;
        alu_b <= op2_d;
      end
      if (state_r == EXEC) begin
        din_RAM  <= alu_res;
        addr_RAM <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_op_fetch_sequencer.sv
// Directed testbench for op_fetch_sequencer.
// Behavioural models of the two ROMs and the ALU sit around the DUT. A negedge
// monitor logs every accepted RAM write and counts protocol violations.
module tb_op_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op_sel;
  logic        en_ROM;
  logic [3:0]  addr_ROM;
  logic [31:0] op1_d;
  logic [31:0] op2_d;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_res;
  logic        we_RAM;
  logic [3:0]  addr_RAM;
  logic [31:0] din_RAM;
  logic        ram_ready;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          viol = 0;
  logic        seen_fetch = 1'b0;
  logic        prev_en = 1'b0;

  op_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .en_ROM(en_ROM), .addr_ROM(addr_ROM), .op1_d(op1_d), .op2_d(op2_d),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .we_RAM(we_RAM), .addr_RAM(addr_RAM), .din_RAM(din_RAM),
    .ram_ready(ram_ready), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom1_f(input logic [3:0] a);
    return 32'h1000_0000 + 32'(a) * 32'h0000_0101;
  endfunction

  function automatic logic [31:0] rom2_f(input logic [3:0] a);
    return 32'(a) * 32'd3 + 32'd5;
  endfunction

  function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'h2:    return a + b;
      4'h3:    return a ^ b;
      default: return a - b;
    endcase
  endfunction

  function automatic logic [31:0] exp_f(input logic [3:0] s, input logic [3:0] a);
    return alu_f(s, rom1_f(a), rom2_f(a));
  endfunction

  assign op1_d   = en_ROM ? rom1_f(addr_ROM) : 32'bz;
  assign op2_d   = en_ROM ? rom2_f(addr_ROM) : 32'bz;
  assign alu_res = alu_f(alu_sel, alu_a, alu_b);

  // Log writes accepted at the coming edge and flag protocol violations.
  always @(negedge clk) begin
    if (we_RAM === 1'b1 && ram_ready === 1'b1) begin
      wr_addr.push_back(addr_RAM);
      wr_data.push_back(din_RAM);
    end
    if (en_ROM === 1'b1 && (we_RAM !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || prev_en === 1'b1)) begin
      viol = viol + 1;
    end
    if (en_ROM === 1'b1) begin
      seen_fetch = 1'b1;
    end
    if (seen_fetch && $isunknown({alu_a, alu_b})) begin
      viol = viol + 1;
    end
    prev_en = en_ROM;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_en_ROM"},   32'(en_ROM),   32'd0);
    chk({tag, "_addr_ROM"}, 32'(addr_ROM), 32'd0);
    chk({tag, "_alu_a"},    alu_a,         32'd0);
    chk({tag, "_alu_b"},    alu_b,         32'd0);
    chk({tag, "_alu_sel"},  32'(alu_sel),  32'd0);
    chk({tag, "_we_RAM"},   32'(we_RAM),   32'd0);
    chk({tag, "_addr_RAM"}, 32'(addr_RAM), 32'd0);
    chk({tag, "_din_RAM"},  din_RAM,       32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Compare the n writes logged from index base against addresses 0..n-1.
  task automatic chk_log(input string tag, input int base, input int n, input logic [3:0] s);
    chk({tag, "_count"}, 32'(wr_addr.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_addr.size()) begin
        chk({tag, "_addr"}, 32'(wr_addr[base + i]), 32'(i));
        chk({tag, "_data"}, wr_data[base + i], exp_f(s, 4'(i)));
      end
    end
  endtask

  // Advance until the given condition holds, at most 'limit' cycles.
  task automatic wait_fetch(input logic [3:0] a, input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (en_ROM === 1'b1 && addr_ROM === a) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_write(input logic [3:0] a, input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (we_RAM === 1'b1 && addr_RAM === a) ok = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int          cyc;
    int          base;
    logic        ok;
    logic [31:0] held;

    rst = 1'b1; start = 1'b0; op_sel = 4'h0; ram_ready = 1'b1;
    tick(); tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Sweep 1: op_sel 2, ram_ready tied high.
    base = wr_addr.size();
    op_sel = 4'h2; start = 1'b1;
    tick();
    start = 1'b0; op_sel = 4'hF;
    chk("s1_fetch_en",   32'(en_ROM),   32'd1);
    chk("s1_fetch_addr", 32'(addr_ROM), 32'd0);
    chk("s1_alu_sel",    32'(alu_sel),  32'h2);
    chk("s1_busy",       32'(busy),     32'd1);
    tick();
    chk("s1_alu_b", alu_b, 32'h0000_0005);
    chk("s1_alu_a", alu_a, rom1_f(4'd0));
    chk("s1_exec_en", 32'(en_ROM), 32'd0);
    tick();
    chk("s1_we",       32'(we_RAM),   32'd1);
    chk("s1_addr_RAM", 32'(addr_RAM), 32'd0);
    chk("s1_din_RAM",  din_RAM,       exp_f(4'h2, 4'd0));
    cyc = 2;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("s1_done_seen",    32'(done), 32'd1);
    chk("s1_done_latency", 32'(cyc),  32'd48);
    chk("s1_done_busy",    32'(busy), 32'd1);
    tick();
    chk("s1_done_pulse", 32'(done),    32'd0);
    chk("s1_busy_fall",  32'(busy),    32'd0);
    chk("s1_sel_kept",   32'(alu_sel), 32'h2);
    chk("s1_alu_a_kept", alu_a,        rom1_f(4'd15));
    chk_log("s1_wr", base, 16, 4'h2);

    // Sweep 2: op_sel 3, start pulsed mid-sweep, stall at address 7.
    base = wr_addr.size();
    op_sel = 4'h3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_fetch(4'd4, 40, ok);
    chk("s2_reach4", 32'(ok), 32'd1);
    start = 1'b1; op_sel = 4'h2;
    tick();
    start = 1'b0;
    chk("s2_mid_start_addr", 32'(addr_ROM), 32'd4);
    chk("s2_mid_start_en",   32'(en_ROM),   32'd0);
    chk("s2_mid_start_sel",  32'(alu_sel),  32'h3);
    wait_write(4'd7, 40, ok);
    chk("s2_reach7", 32'(ok), 32'd1);
    ram_ready = 1'b0;
    held = din_RAM;
    chk("s2_stall_data", held, exp_f(4'h3, 4'd7));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_stall_we",   32'(we_RAM),   32'd1);
      chk("s2_stall_addr", 32'(addr_RAM), 32'd7);
      chk("s2_stall_din",  din_RAM,       held);
    end
    ram_ready = 1'b1;
    tick();
    chk("s2_next_fetch_en",   32'(en_ROM),   32'd1);
    chk("s2_next_fetch_addr", 32'(addr_ROM), 32'd8);
    chk("s2_next_we",         32'(we_RAM),   32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("s2_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s2_done_start_busy", 32'(busy),   32'd0);
    chk("s2_done_start_en",   32'(en_ROM), 32'd0);
    tick();
    chk("s2_still_idle", 32'(busy), 32'd0);
    chk_log("s2_wr", base, 16, 4'h3);

    // Sweep 3: op_sel 5, asynchronous reset during the write at address 10.
    base = wr_addr.size();
    op_sel = 4'h5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s3_restart_addr", 32'(addr_ROM), 32'd0);
    chk("s3_restart_en",   32'(en_ROM),   32'd1);
    chk("s3_sel",          32'(alu_sel),  32'h5);
    wait_write(4'd10, 60, ok);
    chk("s3_reach10", 32'(ok), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs("s3_async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("s3_after_rst_busy", 32'(busy),   32'd0);
    chk("s3_after_rst_en",   32'(en_ROM), 32'd0);
    chk_log("s3_wr", base, 10, 4'h5);

    chk("protocol_violations", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/op_fetch_sequencer.md
Name: op_fetch_sequencer

Overview:
- Control stage directly upstream of the operand ROMs and the ALU.
- On `start`, it walks ROM addresses 0..LAST_ADDR. For each address it enables both operand ROMs, registers their words, and presents them to the ALU with a latched operation select.
- It registers the ALU result and writes it into result RAM at the same address, using a ready handshake.
- Pulses `done` after the last write.

Parameters:
ADDR_W, 4, ROM/RAM address width
DATA_W, 32, operand/result width
SEL_W, 4, ALU operation select width
LAST_ADDR, 15, final address processed (must be ≤ 2^ADDR_W−1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin a sweep; sampled only in IDLE
op_sel  in  SEL_W  ALU operation; latched when start accepted
en_ROM  out  1  enable to both operand ROMs
addr_ROM  out  ADDR_W  address to both operand ROMs
op1_d  in  DATA_W  operand ROM 1 word (combinational; Z when disabled)
op2_d  in  DATA_W  operand ROM 2 word (combinational; Z when disabled)
alu_a  out  DATA_W  registered operand A
alu_b  out  DATA_W  registered operand B
alu_sel  out  SEL_W  latched op_sel
alu_res  in  DATA_W  combinational ALU result
we_RAM  out  1  RAM write request
addr_RAM  out  ADDR_W  RAM write address
din_RAM  out  DATA_W  RAM write data (registered ALU result)
ram_ready  in  1  RAM accepts write this cycle when high with we_RAM
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after final write

Behaviour:
- Reset (async, immediate, any state):
  - State IDLE; address counter 0.
  - All outputs 0: en_ROM, addr_ROM, alu_a, alu_b, alu_sel, we_RAM, addr_RAM, din_RAM, busy, done.
  - Reset mid-sweep abandons the sweep; no write completes after rst asserts.
- IDLE:
  - en_ROM=0, we_RAM=0.
  - start=1 → latch op_sel into alu_sel, clear counter to 0, go to FETCH.
- FETCH (1 cycle):
  - en_ROM=1, addr_ROM=counter.
  - At clock edge: alu_a←op1_d, alu_b←op2_d. Go to EXEC.
  - Operands are captured only in FETCH, so Z from disabled ROMs is never registered.
- EXEC (1 cycle):
  - en_ROM=0; alu_a/alu_b/alu_sel stable.
  - At edge: din_RAM←alu_res, addr_RAM←counter. Go to WRITE.
- WRITE (≥1 cycle):
  - we_RAM=1; addr_RAM/din_RAM held stable while waiting.
  - On an edge with ram_ready=1, the write is accepted:
    - if counter==LAST_ADDR → DONE;
    - else counter←counter+1 → FETCH.
  - ram_ready=0 → stay in WRITE; all outputs held.
- DONE (1 cycle): done=1, busy=1, we_RAM=0 → IDLE.
- Latency with ram_ready tied high: 3 cycles per address, so (LAST_ADDR+1)×3 cycles from the start edge to DONE entry, plus one cycle of done.
- Counter: ADDR_W bits. It never wraps during a sweep, because termination occurs at LAST_ADDR before increment.
- start while busy: ignored; op_sel changes while busy: ignored.
- start high in the same cycle as DONE: not accepted. A new sweep requires start sampled in IDLE.
- ram_ready high outside WRITE: ignored.
- alu_a/alu_b/din_RAM retain their last values in IDLE until the next sweep overwrites them.

Test Plan:
- Reset then start with op_sel=4'h2, ram_ready=1, ROM2 word 0=0x00000005 → cycle 1 en_ROM=1/addr_ROM=0; alu_b=0x00000005 after cycle 1; we_RAM=1 with addr_RAM=0 in cycle 3; alu_sel=4'h2 throughout.
- Full sweep, ram_ready=1 → exactly 16 writes to addresses 0..15 in order; done pulses once, 48 cycles after start accepted; busy falls the cycle after done.
- ram_ready held low 5 cycles at address 7 → we_RAM stays 1 for 6 cycles with addr_RAM=7 and din_RAM unchanged; address 8 fetch begins the cycle after acceptance.
- start pulsed at address 4 mid-sweep and in the DONE cycle → no restart, counter unaffected; sweep ends normally, then a start in IDLE begins a new sweep at address 0.
- rst asserted asynchronously mid-cycle during WRITE at address 10 → all outputs 0 immediately; no write accepted; state IDLE after release.
- Checker: en_ROM never high outside FETCH, and alu_a/alu_b never contain X/Z after the first FETCH.
